// File: rtl/unflatten_stream_pkg.sv
// Shared definitions for the unflatten stage: default map geometry and FSM states.
package unflatten_stream_pkg;

  localparam int CNN_DATA_WIDTH   = 8;
  localparam int POOL_OFMAP_SIZE  = 3;
  localparam int POOL_PIXEL_COUNT = POOL_OFMAP_SIZE * POOL_OFMAP_SIZE;

  typedef enum logic {UF_FILL, UF_FULL} unflatten_state_t;

endpackage

// File: rtl/unflatten_stream_if.sv
// Pixel-stream input and parallel-map output of the unflatten stage.
interface unflatten_stream_if
  import unflatten_stream_pkg::*;
#(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int ROWS       = POOL_OFMAP_SIZE,
  parameter int COLS       = POOL_OFMAP_SIZE
);

  logic [DATA_WIDTH-1:0]                     pixel_in;
  logic                                      pixel_valid;
  logic                                      pixel_last;
  logic                                      pixel_ready;
  logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] map_out;
  logic                                      map_valid;
  logic                                      map_ready;
  logic                                      len_err;

  modport master (
    output pixel_in, pixel_valid, pixel_last, map_ready,
    input  pixel_ready, map_out, map_valid, len_err
  );

  modport slave (
    input  pixel_in, pixel_valid, pixel_last, map_ready,
    output pixel_ready, map_out, map_valid, len_err
  );

endinterface

// File: rtl/unflatten_stream_addr_cnt.sv
// Row/column write-address counter with wrap, last-position flag and clear.
module unflatten_stream_addr_cnt #(
  parameter int ROWS  = 3,
  parameter int COLS  = 3,
  parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             at_last
);

  logic row_end;
  logic col_end;

  assign row_end = (row == ROW_W'(ROWS - 1));
  assign col_end = (col == COL_W'(COLS - 1));
  assign at_last = row_end & col_end;

  // Advance row-major; wrapping past the final position lands back on [0][0].
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/unflatten_stream.sv
// Rebuilds a ROWS x COLS feature map from a row-major pixel stream into a
// single flop-array frame buffer, presents it, then clears for the next frame.
module unflatten_stream
  import unflatten_stream_pkg::*;
#(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int ROWS       = POOL_OFMAP_SIZE,
  parameter int COLS       = POOL_OFMAP_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  unflatten_stream_if.slave bus
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  unflatten_state_t state;
  unflatten_state_t state_next;

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             at_last;
  logic             accept;
  logic             frame_release;
  logic             ready_c;
  logic             valid_c;
  logic             len_err_q;

  logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] map_q;

  // Handshakes are derived from the registered state only.
  assign accept        = bus.pixel_valid & (state == UF_FILL);
  assign frame_release = bus.map_ready & (state == UF_FULL);

  unflatten_stream_addr_cnt #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_addr_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (frame_release),
    .inc     (accept),
    .row     (row),
    .col     (col),
    .at_last (at_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= UF_FILL;
    else       state <= state_next;
  end

  // Next state and handshake outputs; a frame ends at the last slot or on an early pixel_last.
  always_comb begin
    state_next = state;
    ready_c    = 1'b0;
    valid_c    = 1'b0;
    case (state)
      UF_FILL: begin
        ready_c = 1'b1;
        if (accept && (at_last || bus.pixel_last)) state_next = UF_FULL;
      end
      UF_FULL: begin
        valid_c = 1'b1;
        if (frame_release) state_next = UF_FILL;
      end
      default: state_next = UF_FILL;
    endcase
  end

  // Frame buffer: write the addressed slot on accept, wipe everything on release so
  // entries skipped by an early end read back as zero.
  always_ff @(posedge clk) begin
    if (reset || frame_release) map_q <= '0;
    else if (accept)            map_q[row][col] <= bus.pixel_in;
  end

  // Length error: pixel_last and the final slot must coincide on the same accept.
  always_ff @(posedge clk) begin
    if (reset) len_err_q <= 1'b0;
    else       len_err_q <= accept & (at_last ^ bus.pixel_last);
  end

  assign bus.pixel_ready = ready_c;
  assign bus.map_valid   = valid_c;
  assign bus.map_out     = map_q;
  assign bus.len_err     = len_err_q;

endmodule
